// File: rtl/pcileech_tx_sched.sv
// ----------------------------------------------------------------------------
// pcileech_tx_sched
//
// Shares the 34-bit USB TX packing path between four source FIFOs
// (0 = PCIe TLP, 1 = PCIe CFG, 2 = loopback, 3 = command). Decides which
// source gets each read strobe, keeps port-0 TLPs atomic, stops port 0 from
// starving ports 1-3, and forwards every returned word as a registered
// {ctx, data} beat tagged with its source index.
//
// Handshake: a strobe on p_req_data[n] in cycle t is an unconditional pop of
// source n; that source answers with p_valid[n] in cycle t+1, and the word
// leaves on dout/dout_valid in cycle t+2. There is no back-pressure on the
// return path, so a strobe is only issued while the packer is not almost full
// (sink_afull low), which leaves room for the word still in flight.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   p_has_data[3:0]   source n FIFO not empty
//   p_req_data[3:0]   read strobe to source n, at most one bit high
//   p_valid[3:0]      source n data valid, one cycle after its strobe
//   p_din[127:0]      source n word at [32n+31:32n]
//   p_ctx[7:0]        source n ctx at [2n+1:2n]; port 0 ctx[0] = last of TLP
//   sink_afull        packer almost full
//   dout[33:0]        {ctx, data}, registered
//   dout_valid        dout qualifier
//   dout_port[1:0]    source index of dout
//   active            in LOCK0 or a read outstanding
//   dbg_state_o       current FSM state (0 = IDLE, 1 = LOCK0)
//
// Build option: define PCILEECH_TX_SCHED_RR_EN to serve ports 1-3
// round-robin; otherwise they are served in fixed priority 1 > 2 > 3.
// ----------------------------------------------------------------------------
module pcileech_tx_sched #(
    parameter int unsigned PARAM_STARVE_LIMIT = 8,
    parameter int unsigned PARAM_CNT_W        = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   p_has_data,
    output logic [3:0]   p_req_data,
    input  logic [3:0]   p_valid,
    input  logic [127:0] p_din,
    input  logic [7:0]   p_ctx,
    input  logic         sink_afull,
    output logic [33:0]  dout,
    output logic         dout_valid,
    output logic [1:0]   dout_port,
    output logic         active,
    output logic         dbg_state_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_LOCK0 = 1'b1;

    localparam logic [PARAM_CNT_W-1:0] STARVE_LIMIT = PARAM_CNT_W'(PARAM_STARVE_LIMIT);
    localparam logic [PARAM_CNT_W-1:0] CNT_MAX      = '1;

    logic [0:0]             state_q, state_d;
    logic [PARAM_CNT_W-1:0] cnt_q, cnt_d;
    logic                   outstanding_q;
    logic [33:0]            dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic [1:0]             dout_port_q, dout_port_d;

    logic       last0_arriving;
    logic       others_wait;
    logic       starve_block;
    logic [1:0] lo_sel;
    logic       lo_grant;
    logic [3:0] req;

    assign last0_arriving = p_valid[0] & p_ctx[0];
    assign others_wait    = |p_has_data[3:1];
    // Port 0 is only held back when someone else can actually take the slot.
    assign starve_block   = (PARAM_STARVE_LIMIT != 0) && (cnt_q >= STARVE_LIMIT) && others_wait;

`ifdef PCILEECH_TX_SCHED_RR_EN
    logic [1:0] rr_q, rr_d;
    logic [1:0] cand;
    logic       found;

    // Search ports 1..3 starting at the pointer, wrapping 3 -> 1.
    always_comb begin
        lo_sel = 2'd3;
        cand   = rr_q;
        found  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found && p_has_data[cand]) begin
                lo_sel = cand;
                found  = 1'b1;
            end
            cand = (cand == 2'd3) ? 2'd1 : cand + 2'd1;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (lo_grant) begin
            rr_d = (lo_sel == 2'd3) ? 2'd1 : lo_sel + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 2'd1;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        if (p_has_data[1]) begin
            lo_sel = 2'd1;
        end else if (p_has_data[2]) begin
            lo_sel = 2'd2;
        end else begin
            lo_sel = 2'd3;
        end
    end
`endif

    // Grant decision and FSM.
    always_comb begin
        req      = 4'b0000;
        state_d  = state_q;
        cnt_d    = cnt_q;
        lo_grant = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!sink_afull && (|p_has_data)) begin
                    if (p_has_data[0] && !starve_block) begin
                        req[0]  = 1'b1;
                        state_d = ST_LOCK0;
                        if (others_wait && (cnt_q != CNT_MAX)) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        req[lo_sel] = 1'b1;
                        lo_grant    = 1'b1;
                        cnt_d       = '0;
                    end
                end
            end
            default: begin
                // The word strobed last cycle closes the packet: do not touch
                // the next packet, hand the slot back to IDLE instead.
                if (last0_arriving) begin
                    state_d = ST_IDLE;
                end else if (p_has_data[0] && !sink_afull) begin
                    req[0] = 1'b1;
                end
            end
        endcase
    end

    // Output register; lowest index wins if several valids ever coincide.
    always_comb begin
        dout_valid_d = 1'b0;
        dout_d       = dout_q;
        dout_port_d  = dout_port_q;
        for (int n = 3; n >= 0; n--) begin
            if (p_valid[n]) begin
                dout_valid_d = 1'b1;
                dout_d       = {p_ctx[2*n +: 2], p_din[32*n +: 32]};
                dout_port_d  = 2'(n);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            outstanding_q <= 1'b0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            dout_port_q   <= 2'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            outstanding_q <= |req;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            dout_port_q   <= dout_port_d;
        end
    end

    // Strobes are combinational, so they are masked while reset is held to
    // keep the sources from being popped during reset.
    assign p_req_data  = rst_n ? req : 4'b0000;
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign dout_port   = dout_port_q;
    assign active      = (state_q == ST_LOCK0) | outstanding_q;
    assign dbg_state_o = state_q[0];

endmodule

// File: tb/tb_pcileech_tx_sched.sv
// ----------------------------------------------------------------------------
// Testbench for pcileech_tx_sched: behavioural source FIFOs, an expected-word
// queue with due cycles, rule-level checks on every strobe, directed cases and
// a randomized soak.
// ----------------------------------------------------------------------------
module tb_pcileech_tx_sched;

    localparam int LIMIT = 2;
    localparam int CW    = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]   p_has_data;
    logic [3:0]   p_req_data;
    logic [3:0]   p_valid;
    logic [127:0] p_din;
    logic [7:0]   p_ctx;
    logic         sink_afull;
    logic [33:0]  dout;
    logic         dout_valid;
    logic [1:0]   dout_port;
    logic         active;
    logic         dbg_state_o;

    pcileech_tx_sched #(
        .PARAM_STARVE_LIMIT(LIMIT),
        .PARAM_CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .p_has_data (p_has_data),
        .p_req_data (p_req_data),
        .p_valid    (p_valid),
        .p_din      (p_din),
        .p_ctx      (p_ctx),
        .sink_afull (sink_afull),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_port  (dout_port),
        .active     (active),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- bench state ----------------
    int total = 0;
    int bad   = 0;

    logic [33:0] src_mem [4][64];
    int          src_hd [4];
    int          src_tl [4];

    logic [63:0] exp_q[$];     // {due_cycle[27:0], port[1:0], word[33:0]}
    int          gnt_q[$];
    int          gnt_cyc[$];
    int          exp_g[$];

    logic [27:0] cyc = '0;
    logic        pend_v;
    logic [1:0]  pend_port;
    logic [33:0] pend_word;
    logic [3:0]  hd_mask;
    logic        afull_cfg;
    logic        p0_open;
    int          starve_cnt;
    int          rr_ptr;
    logic        out_seen;
    logic        strobe_seen;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_gnt(input string tag);
        check_eq({tag, "_gnt_count"}, 64'(gnt_q.size()), 64'(exp_g.size()));
        for (int i = 0; i < exp_g.size() && i < gnt_q.size(); i++) begin
            check_eq({tag, "_gnt_order"}, 64'(gnt_q[i]), 64'(exp_g[i]));
        end
    endtask

    // Which of ports 1..3 the rules say should win, given visible data.
    function automatic int pick_lo(input logic [3:0] vis);
        int   res;
        int   c;
        logic found;
        res   = 3;
        found = 1'b0;
`ifdef PCILEECH_TX_SCHED_RR_EN
        c = rr_ptr;
        for (int k = 0; k < 3; k++) begin
            if (!found && vis[c]) begin
                res   = c;
                found = 1'b1;
            end
            c = (c == 3) ? 1 : c + 1;
        end
`else
        c = 0;
        for (int k = 1; k < 4; k++) begin
            if (!found && vis[k]) begin
                res   = k;
                found = 1'b1;
            end
        end
`endif
        return res;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_word(input int p, input logic [1:0] ctx, input logic [31:0] data);
        if (src_hd[p] == src_tl[p]) begin
            src_hd[p] = 0;
            src_tl[p] = 0;
        end
        src_mem[p][src_tl[p]] = {ctx, data};
        src_tl[p]++;
    endtask

    task automatic load_tlp(input int len);
        for (int i = 0; i < len; i++) begin
            push_word(0, {1'($urandom), (i == len - 1) ? 1'b1 : 1'b0}, $urandom);
        end
    endtask

    function automatic logic all_empty();
        logic e;
        e = 1'b1;
        for (int p = 0; p < 4; p++) begin
            if (src_hd[p] != src_tl[p]) e = 1'b0;
        end
        return e;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        for (int p = 0; p < 4; p++) begin
            src_hd[p] = 0;
            src_tl[p] = 0;
        end
        exp_q.delete();
        gnt_q.delete();
        gnt_cyc.delete();
        pend_v     = 1'b0;
        pend_port  = 2'd0;
        pend_word  = '0;
        p0_open    = 1'b0;
        starve_cnt = 0;
        rr_ptr     = 1;
        hd_mask    = 4'b0;
        afull_cfg  = 1'b0;
        p_has_data = 4'b0;
        p_valid    = 4'b0;
        p_din      = '0;
        p_ctx      = '0;
        sink_afull = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: check output, drive sources, judge the strobe, let it pop.
    task automatic step();
        logic [3:0]  req;
        logic [3:0]  vis;
        logic [33:0] w;
        logic [63:0] e;
        int          n;
        @(negedge clk);
        cyc      = cyc + 28'd1;
        out_seen = dout_valid;
        if (exp_q.size() > 0 && exp_q[0][63:36] == cyc) begin
            e = exp_q.pop_front();
            check_eq("dout", {27'd0, dout_valid, dout_port, dout}, {27'd0, 1'b1, e[35:0]});
        end else begin
            check_eq("dout_valid_idle", 64'(dout_valid), 64'd0);
        end

        vis = 4'b0;
        for (int p = 0; p < 4; p++) begin
            if (src_hd[p] != src_tl[p] && !hd_mask[p]) vis[p] = 1'b1;
        end
        p_din   = {$urandom, $urandom, $urandom, $urandom};
        p_ctx   = 8'($urandom);
        p_valid = 4'b0;
        if (pend_v) begin
            p_valid[pend_port]          = 1'b1;
            p_din[32*pend_port +: 32]   = pend_word[31:0];
            p_ctx[2*pend_port +: 2]     = pend_word[33:32];
        end
        p_has_data = vis;
        sink_afull = afull_cfg;
        #1;
        req         = p_req_data;
        strobe_seen = (req != 4'b0);
        check_eq("req_onehot", 64'($countones(req) <= 1), 64'd1);
        if (afull_cfg) check_eq("req_afull", 64'(req), 64'd0);
        check_eq("req_visible", 64'(req & ~vis), 64'd0);

        n = -1;
        w = '0;
        for (int p = 3; p >= 0; p--) begin
            if (req[p]) n = p;
        end
        if (n >= 0) begin
            w = src_mem[n][src_hd[n]];
            src_hd[n]++;
            if (n == 0) begin
                if (!p0_open) begin
                    if (|vis[3:1]) starve_cnt++;
                    check_eq("starve_bound", 64'(starve_cnt <= LIMIT), 64'd1);
                end
                p0_open = !w[32];
            end else begin
                check_eq("tlp_atomic", 64'(p0_open), 64'd0);
                if (vis[0]) check_eq("p0_priority", 64'(starve_cnt >= LIMIT), 64'd1);
                check_eq("lo_pick", 64'(n), 64'(pick_lo(vis)));
                rr_ptr     = (n == 3) ? 1 : n + 1;
                starve_cnt = 0;
            end
            exp_q.push_back({cyc + 28'd2, 2'(n), w});
            gnt_q.push_back(n);
            gnt_cyc.push_back(int'(cyc));
        end
        @(posedge clk);
        pend_v = (n >= 0);
        if (n >= 0) begin
            pend_port = 2'(n);
            pend_word = w;
        end
    endtask

    task automatic drain(input string tag, input int budget, input logic rnd);
        int k;
        k = 0;
        while (!(all_empty() && exp_q.size() == 0 && !pend_v) && k < budget) begin
            if (rnd) begin
                afull_cfg = ($urandom_range(0, 3) == 0);
                hd_mask   = {($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0),
                             ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0)};
            end
            step();
            k++;
        end
        afull_cfg = 1'b0;
        hd_mask   = 4'b0;
        check_eq({tag, "_drained"}, 64'(k < budget), 64'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int outs;
        int strobes;
        rst_n      = 1'b0;
        p_has_data = 4'hF;
        p_valid    = 4'b0;
        p_din      = '0;
        p_ctx      = '0;
        sink_afull = 1'b0;
        afull_cfg  = 1'b0;
        hd_mask    = 4'b0;
        pend_v     = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_req",        64'(p_req_data),  64'd0);
        check_eq("rst_dout",       64'(dout),        64'd0);
        check_eq("rst_dout_valid", 64'(dout_valid),  64'd0);
        check_eq("rst_dout_port",  64'(dout_port),   64'd0);
        check_eq("rst_active",     64'(active),      64'd0);
        check_eq("rst_state",      64'(dbg_state_o), 64'd0);

        // 4-word TLP on port 0 plus one port-2 word.
        do_reset();
        load_tlp(4);
        push_word(2, 2'($urandom), $urandom);
        drain("t1", 40, 1'b0);
        exp_g = '{0, 0, 0, 0, 2};
        check_gnt("t1");
        if (gnt_cyc.size() >= 4) check_eq("t1_burst", 64'(gnt_cyc[3] - gnt_cyc[0]), 64'd3);

        // sink_afull for 5 cycles in the middle of an 8-word TLP.
        do_reset();
        load_tlp(8);
        repeat (3) step();
        afull_cfg = 1'b1;
        outs      = 0;
        strobes   = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i >= 1 && out_seen) outs++;
            if (strobe_seen) strobes++;
        end
        afull_cfg = 1'b0;
        check_eq("t2_afull_strobes", 64'(strobes), 64'd0);
        check_eq("t2_inflight_words", 64'(outs), 64'd1);
        drain("t2", 60, 1'b0);
        exp_g = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_gnt("t2");

        // Starvation guard: five single-word port-0 packets vs one port-3 word.
        do_reset();
        for (int i = 0; i < 5; i++) load_tlp(1);
        push_word(3, 2'($urandom), $urandom);
        drain("t3", 60, 1'b0);
        exp_g = '{0, 0, 3, 0, 0, 0};
        check_gnt("t3");

        // Port 0 runs dry for 3 cycles mid-packet while port 1 waits.
        do_reset();
        load_tlp(5);
        push_word(1, 2'($urandom), $urandom);
        push_word(1, 2'($urandom), $urandom);
        repeat (2) step();
        hd_mask = 4'b0001;
        repeat (3) step();
        hd_mask = 4'b0000;
        drain("t4", 60, 1'b0);
        exp_g = '{0, 0, 0, 0, 0, 1, 1};
        check_gnt("t4");
        if (gnt_cyc.size() >= 6) check_eq("t4_gap", 64'(gnt_cyc[5] - gnt_cyc[4]), 64'd2);

        // Reset while a port-0 read is outstanding.
        do_reset();
        load_tlp(4);
        repeat (2) step();
        #2;
        check_eq("t5_pre_valid",  64'(dout_valid),  64'd1);
        check_eq("t5_pre_active", 64'(active),      64'd1);
        check_eq("t5_pre_state",  64'(dbg_state_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_req",    64'(p_req_data),  64'd0);
        check_eq("t5_rst_valid",  64'(dout_valid),  64'd0);
        check_eq("t5_rst_active", 64'(active),      64'd0);
        check_eq("t5_rst_state",  64'(dbg_state_o), 64'd0);
        do_reset();
        push_word(1, 2'($urandom), $urandom);
        load_tlp(2);
        drain("t5", 40, 1'b0);
        exp_g = '{0, 0, 1};
        check_gnt("t5");

        // Ports 1-3 holding two words each.
        do_reset();
        for (int p = 1; p < 4; p++) begin
            push_word(p, 2'($urandom), $urandom);
            push_word(p, 2'($urandom), $urandom);
        end
        drain("t6", 40, 1'b0);
`ifdef PCILEECH_TX_SCHED_RR_EN
        exp_g = '{1, 2, 3, 1, 2, 3};
`else
        exp_g = '{1, 1, 2, 2, 3, 3};
`endif
        check_gnt("t6");

        // Randomized soak: random packets, random afull and empty windows.
        do_reset();
        for (int r = 0; r < 30; r++) begin
            int np;
            np = $urandom_range(0, 3);
            for (int i = 0; i < np; i++) load_tlp($urandom_range(1, 4));
            for (int p = 1; p < 4; p++) begin
                int nw;
                nw = $urandom_range(0, 3);
                for (int i = 0; i < nw; i++) push_word(p, 2'($urandom), $urandom);
            end
            drain("rnd", 600, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
